// File: rtl/blkmux_seq.sv
// -----------------------------------------------------------------------------
// blkmux_seq - readout sequencer for the CFEB block multiplexer.
//
// On each accepted readout request the sequencer walks NSAMP time samples.
// Each sample is 96 data cycles and then NTRL trailer cycles:
//   - Data cycles: the active-low chip enables rotate across the six chips
//     for each of the 16 channels.
//   - Trailer cycles: OE_B is parked and OECRC strobes on the first one.
// START marks the first data word of every sample. DONE marks the end of
// the event.
//
// A request that arrives while a sequence is running is held as a single
// pending request. Any further request is dropped and flagged on OVERRUN.
//
// Optional feature (compile-time macro BLKMUX_SEQ_BCODE_EN):
//   When this macro is defined, a request latched with BREQ=1 runs as a
//   B-code event:
//     - DLOAD is high for the data cycles.
//     - OE_B stays at 6'h3F throughout.
//     - All timing is the same as a normal event.
//   When this macro is undefined, DLOAD is always 0.
//
// Ports:
//   CLK25    in   system clock, rising edge
//   clr_oec  in   asynchronous active-high reset
//   REQ      in   readout request level (rising edge used)
//   BREQ     in   B-code qualifier, sampled with the REQ edge
//   NSAMP    in   [4:0] samples per event, latched at acceptance
//   START    out  first word of each sample
//   DLOAD    out  DATA passthrough select for blkmux
//   OE_B     out  [5:0] one-hot-low chip enable, 6'h3F when inactive
//   OECRC    out  trailer strobe, first trailer cycle of each sample
//   SAMPLE   out  [4:0] current sample index
//   CHAN     out  [3:0] current channel index
//   BUSY     out  sequence in progress
//   DONE     out  end-of-event pulse
//   OVERRUN  out  sticky: request lost while one was already pending
// -----------------------------------------------------------------------------
module blkmux_seq #(
  parameter int NCHAN = 16,
  parameter int NCHIP = 6,
  parameter int NTRL  = 4
) (
  input  logic       CLK25,
  input  logic       clr_oec,
  input  logic       REQ,
  input  logic       BREQ,
  input  logic [4:0] NSAMP,
  output logic       START,
  output logic       DLOAD,
  output logic [5:0] OE_B,
  output logic       OECRC,
  output logic [4:0] SAMPLE,
  output logic [3:0] CHAN,
  output logic       BUSY,
  output logic       DONE,
  output logic       OVERRUN
);

`ifdef BLKMUX_SEQ_BCODE_EN
  localparam logic BCODE_EN = 1'b1;
`else
  localparam logic BCODE_EN = 1'b0;
`endif

  localparam int         TRL_W     = (NTRL > 1) ? $clog2(NTRL) : 1;
  localparam logic [2:0] CHIP_LAST = 3'(NCHIP - 1);
  localparam logic [3:0] CHAN_LAST = 4'(NCHAN - 1);
  localparam logic [TRL_W-1:0] TRL_LAST = TRL_W'(NTRL - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_TRAIL = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]       state_reg, state_next;
  logic [2:0]       chip_reg, chip_next;
  logic [3:0]       chan_reg, chan_next;
  logic [4:0]       samp_reg, samp_next;
  logic [TRL_W-1:0] trl_reg, trl_next;
  logic [4:0]       nsamp_reg, nsamp_next;
  logic             breq_reg, breq_next;
  logic             pend_reg, pend_next;
  logic [4:0]       shd_nsamp_reg, shd_nsamp_next;
  logic             shd_breq_reg, shd_breq_next;
  logic             ovr_reg, ovr_next;
  logic             req_1_reg;
  logic             req_edge;
  logic             bcode_next;
  logic [NCHIP-1:0] oe_dec_next;

  logic             start_reg;
  logic             dload_reg;
  logic [5:0]       oe_b_reg;
  logic             oecrc_reg;
  logic             busy_reg;
  logic             done_reg;

  assign req_edge = REQ & ~req_1_reg;

  // Next-state and counter logic.
  always_comb begin
    state_next     = state_reg;
    chip_next      = chip_reg;
    chan_next      = chan_reg;
    samp_next      = samp_reg;
    trl_next       = trl_reg;
    nsamp_next     = nsamp_reg;
    breq_next      = breq_reg;
    pend_next      = pend_reg;
    shd_nsamp_next = shd_nsamp_reg;
    shd_breq_next  = shd_breq_reg;
    ovr_next       = ovr_reg;

    case (state_reg)
      S_IDLE: begin
        if (req_edge) begin
          nsamp_next = NSAMP;
          breq_next  = BREQ;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        state_next = (nsamp_reg == 5'd0) ? S_FIN : S_DATA;
      end
      S_DATA: begin
        if (chip_reg == CHIP_LAST) begin
          chip_next = 3'd0;
          if (chan_reg == CHAN_LAST) begin
            chan_next  = 4'd0;
            trl_next   = '0;
            state_next = S_TRAIL;
          end else begin
            chan_next = chan_reg + 4'd1;
          end
        end else begin
          chip_next = chip_reg + 3'd1;
        end
      end
      S_TRAIL: begin
        if (trl_reg == TRL_LAST) begin
          if (samp_reg == nsamp_reg - 5'd1) begin
            state_next = S_FIN;
          end else begin
            samp_next  = samp_reg + 5'd1;
            state_next = S_DATA;
          end
        end else begin
          trl_next = trl_reg + 1'b1;
        end
      end
      S_FIN: begin
        if (pend_reg) begin
          // Held request starts immediately. An edge on this same cycle
          // collides with a still-pending request and is lost.
          nsamp_next = shd_nsamp_reg;
          breq_next  = shd_breq_reg;
          pend_next  = 1'b0;
          state_next = S_LOAD;
          if (req_edge) begin
            ovr_next = 1'b1;
          end
        end else if (req_edge) begin
          // Nothing held: a fresh edge here is taken directly, otherwise it
          // would be parked as pending after the machine has gone idle.
          nsamp_next = NSAMP;
          breq_next  = BREQ;
          state_next = S_LOAD;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Requests during an active sequence (FIN handled above).
    if (req_edge && state_reg != S_IDLE && state_reg != S_FIN) begin
      if (pend_reg) begin
        ovr_next = 1'b1;
      end else begin
        pend_next      = 1'b1;
        shd_nsamp_next = NSAMP;
        shd_breq_next  = BREQ;
      end
    end

    // Every event starts from sample 0, channel 0, chip 0.
    if (state_next == S_LOAD) begin
      chip_next = 3'd0;
      chan_next = 4'd0;
      samp_next = 5'd0;
      trl_next  = '0;
    end
  end

  assign bcode_next = breq_next & BCODE_EN;

  // Active-low chip decode of the upcoming chip index.
  genvar gi;
  generate
    for (gi = 0; gi < NCHIP; gi++) begin : g_oe_dec
      assign oe_dec_next[gi] = (chip_next != 3'(gi));
    end
  endgenerate

  always_ff @(posedge CLK25 or posedge clr_oec) begin
    if (clr_oec) begin
      state_reg     <= S_IDLE;
      chip_reg      <= 3'd0;
      chan_reg      <= 4'd0;
      samp_reg      <= 5'd0;
      trl_reg       <= '0;
      nsamp_reg     <= 5'd0;
      breq_reg      <= 1'b0;
      pend_reg      <= 1'b0;
      shd_nsamp_reg <= 5'd0;
      shd_breq_reg  <= 1'b0;
      ovr_reg       <= 1'b0;
      req_1_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      chip_reg      <= chip_next;
      chan_reg      <= chan_next;
      samp_reg      <= samp_next;
      trl_reg       <= trl_next;
      nsamp_reg     <= nsamp_next;
      breq_reg      <= breq_next;
      pend_reg      <= pend_next;
      shd_nsamp_reg <= shd_nsamp_next;
      shd_breq_reg  <= shd_breq_next;
      ovr_reg       <= ovr_next;
      req_1_reg     <= REQ;
    end
  end

  // Outputs are registered from next-state values, so they line up with the
  // state and counters that they describe.
  always_ff @(posedge CLK25 or posedge clr_oec) begin
    if (clr_oec) begin
      start_reg <= 1'b0;
      dload_reg <= 1'b0;
      oe_b_reg  <= 6'h3F;
      oecrc_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      start_reg <= (state_next == S_DATA) && (chip_next == 3'd0) && (chan_next == 4'd0);
      dload_reg <= (state_next == S_DATA) && bcode_next;
      oe_b_reg  <= ((state_next == S_DATA) && !bcode_next) ? oe_dec_next : 6'h3F;
      oecrc_reg <= (state_next == S_TRAIL) && (trl_next == '0);
      busy_reg  <= (state_next != S_IDLE);
      done_reg  <= (state_next == S_FIN);
    end
  end

  assign START   = start_reg;
  assign DLOAD   = dload_reg;
  assign OE_B    = oe_b_reg;
  assign OECRC   = oecrc_reg;
  assign SAMPLE  = samp_reg;
  assign CHAN    = chan_reg;
  assign BUSY    = busy_reg;
  assign DONE    = done_reg;
  assign OVERRUN = ovr_reg;

endmodule

// File: doc/blkmux_seq.md
# blkmux_seq

Readout sequencer for the CFEB block multiplexer. On each readout request it walks the time samples of one event. For every sample it rotates the active-low ADC output enables across the six chips for each of 16 channels, and brackets each sample with a CRC-clear `START` pulse and an `OECRC` trailer strobe. It sits between the L1A/readout control logic and `blkmux`, driving that block's `START`, `DLOAD`, `OE_B` and `OECRC` inputs.

## Interface
Parameters:
- `NCHAN`, 16: channels per chip per sample.
- `NCHIP`, 6: chips rotated by `OE_B`; fixed to match the `OE_B` width.
- `NTRL`, 4: trailer cycles per sample (CRC, status, L1A, ~CRC).

Ports:
- `CLK25`, in, 1: system clock; all logic on the rising edge.
- `clr_oec`, in, 1: reset, asynchronous, active-high; clock CLK25.
- `REQ`, in, 1: readout request, level; the rising edge is used.
- `BREQ`, in, 1: B-code request qualifier, sampled with the `REQ` edge; used only with `BCODE_EN`.
- `NSAMP`, in, 5: samples per event, 0..31; latched at acceptance.
- `START`, out, 1: one-cycle pulse on the first word of each sample.
- `DLOAD`, out, 1: high selects `DATA` passthrough (B-code) in `blkmux`.
- `OE_B`, out, 6: one-hot-low chip enable; `6'h3F` when idle.
- `OECRC`, out, 1: one-cycle trailer strobe.
- `SAMPLE`, out, 5: current sample index.
- `CHAN`, out, 4: current channel index.
- `BUSY`, out, 1: sequence in progress.
- `DONE`, out, 1: one-cycle end-of-event pulse.
- `OVERRUN`, out, 1: sticky flag for a request lost while one is already pending; cleared only by reset.

## Operation
- States:
  - `IDLE`: waiting for an accepted request.
  - `LOAD`: one cycle after acceptance.
  - `DATA`: `NCHAN*NCHIP` = 96 cycles per sample.
  - `TRAIL`: `NTRL` cycles per sample.
  - `FIN`: one cycle.
- `IDLE`:
  - A `REQ` rising edge (`REQ & !req_1`) is accepted.
  - `NSAMP` and `BREQ` are latched and the machine goes to `LOAD`.
- `LOAD`:
  - `SAMPLE`, `CHAN` and the chip index are cleared.
  - If the latched `NSAMP` is 0, go to `FIN`; otherwise go to `DATA`.
- `DATA`:
  - `OE_B = ~(6'b1 << chip)`.
  - The chip index increments 0..5 every cycle. On a wrap from 5 to 0, `CHAN` increments.
  - After chip 5 / channel 15, go to `TRAIL`.
  - `START` is high on the cycle with chip 0 / channel 0.
- `TRAIL`:
  - `OE_B = 6'h3F`.
  - `OECRC` is high in the first trailer cycle only.
  - After `NTRL` cycles: if `SAMPLE == NSAMP-1`, go to `FIN`; else increment `SAMPLE` and return to `DATA`.
- `FIN`:
  - `DONE = 1` for one cycle, then go to `IDLE`.
  - A pending request is accepted on the same edge.
- `BUSY` is high in every state except `IDLE`.
- Pending request:
  - A `REQ` rising edge while `BUSY` sets `pend` and latches `NSAMP`/`BREQ` into a shadow register.
  - A further edge while `pend` is set sets `OVERRUN` and leaves the shadow register unchanged.
  - The transition from `FIN` goes to `LOAD` if `pend` is set, clearing `pend`.
- Reset values:
  - `OE_B = 6'h3F`; `START`, `DLOAD`, `OECRC`, `BUSY`, `DONE`, `OVERRUN` = 0.
  - `SAMPLE` = 0, `CHAN` = 0, `pend` = 0, state = `IDLE`.
- Reset mid-sequence: all outputs return to their reset values immediately (asynchronous). No `DONE` or `OECRC` is emitted, and the pending request is discarded.
- All outputs are registered.

## Timing
- `REQ` first sampled high at edge k:
  - After edge k: `BUSY=1`, state `LOAD`.
  - After edge k+1: first data word, with `START=1` and `OE_B=6'b111110`.
- Each sample spans 100 cycles: 96 data plus 4 trailer.
  - `OECRC` is high in cycle 97 of each sample, relative to that sample's `START` cycle 1.
- Event of N≥1 samples:
  - `DONE` is high 1 + 100N cycles after the `LOAD` cycle.
  - `BUSY` falls on the edge that ends `DONE`, unless a pending request is taken.
- `NSAMP=0`: `DONE` follows `LOAD` by one cycle; no `START`, `OECRC` or `OE_B` activity.
- Back-to-back event: `LOAD` of the pending event directly follows `FIN`, with `BUSY` staying high.

## Configuration
- `BLKMUX_SEQ_BCODE_EN` defined:
  - If the latched `BREQ` is 1, `DLOAD=1` during `DATA` and `OE_B` is held at `6'h3F`.
  - Counters, `START`, `OECRC` and cycle counts are identical to a normal event.
- Macro undefined:
  - `BREQ` is ignored.
  - `DLOAD` is constant 0.

## Test plan
- `NSAMP=1`, single `REQ` pulse:
  - 96 `OE_B` words cycle chips 1..6 across 16 channels.
  - `START` on word 1, `OECRC` on cycle 97.
  - `DONE` 102 cycles after `REQ` is sampled; `OE_B=6'h3F` afterwards.
- `NSAMP=8`:
  - Exactly 8 `START` and 8 `OECRC` pulses.
  - `SAMPLE` steps 0..7.
  - `DONE` occurs 802 cycles after `REQ` is sampled.
- `NSAMP=0`: `DONE` 2 cycles after `REQ`; no `START` or `OECRC`; `OE_B` never leaves `6'h3F`.
- Overlapping requests:
  - Second `REQ` mid-event: second event's `LOAD` immediately follows `FIN`, using the second `NSAMP`.
  - Third `REQ` before then: `OVERRUN=1` and that request is dropped.
- Reset during sample 3, channel 7: outputs return to reset values asynchronously; a later `REQ` restarts from sample 0, channel 0.
- With `BLKMUX_SEQ_BCODE_EN` and `BREQ=1`, `NSAMP=2`: `DLOAD=1` for 96 cycles per sample, `OE_B=6'h3F` throughout, two `OECRC` pulses.
